// File: rtl/hs4_rr_arbiter_pkg.sv
// Shared definitions for the 4-phase round-robin arbiter: FSM state encoding
// and counter widths.
package hs4_rr_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_GAP     = 2'd2,
    ST_WAITREL = 2'd3
  } arb_state_e;

  localparam int GAP_W   = 4;
  localparam int MAX_GAP = 15;
  localparam int HOLD_W  = 16;

endpackage

// File: rtl/hs4_rr_arbiter_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface hs4_rr_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
);
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic             gnt_valid;
  logic [IDX_W-1:0] gnt_idx;
  logic             busy;
  logic             timeout;
  logic [N_REQ-1:0] revoked;

  modport master (output req, input gnt, gnt_valid, gnt_idx, busy, timeout, revoked);
  modport slave  (input req, output gnt, gnt_valid, gnt_idx, busy, timeout, revoked);
endinterface

// File: rtl/hs4_rr_arbiter_rr_pick.sv
// Rotating priority encoder: first set request bit at or after i_ptr, wrapping
// modulo N_REQ so non-power-of-2 requester counts are handled.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_onehot,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  localparam logic [N_REQ-1:0] ONE_N = {{(N_REQ-1){1'b0}}, 1'b1};

  int w_cand;

  // Scan ptr, ptr+1, ... and keep the first hit.
  always_comb begin
    w_cand   = 0;
    o_any    = 1'b0;
    o_idx    = {IDX_W{1'b0}};
    for (int k = 0; k < N_REQ; k++) begin
      w_cand = int'(i_ptr) + k;
      if (w_cand >= N_REQ) begin
        w_cand = w_cand - N_REQ;
      end else begin
        w_cand = w_cand;
      end
      if (!o_any && i_req[w_cand[IDX_W-1:0]]) begin
        o_any = 1'b1;
        o_idx = w_cand[IDX_W-1:0];
      end else begin
        o_any = o_any;
      end
    end
    o_onehot = o_any ? (ONE_N << o_idx) : {N_REQ{1'b0}};
  end

endmodule

// File: rtl/hs4_rr_arbiter.sv
// N-way round-robin arbiter with a 4-phase req/gnt handshake, mandatory idle
// gap between grants and an optional hold watchdog that revokes stuck grants.
module hs4_rr_arbiter
  import hs4_rr_arbiter_pkg::*;
#(
  parameter int          N_REQ    = 4,
  parameter int          IDX_W    = $clog2(N_REQ),
  parameter int          GAP_CYC  = 1,
  parameter logic [15:0] MAX_HOLD = 16'd0
) (
  input logic             clk,
  input logic             rst_sync,
  hs4_rr_arbiter_if.slave bus
);

  localparam logic [N_REQ-1:0] ONE_N    = {{(N_REQ-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);
  localparam logic [GAP_W-1:0] GAP_LIM  = GAP_W'(GAP_CYC);
  localparam arb_state_e       ST_REL   = (GAP_CYC == 0) ? ST_IDLE : ST_GAP;

  arb_state_e        r_state, w_state_nxt;
  logic [N_REQ-1:0]  r_gnt, w_gnt_nxt;
  logic [IDX_W-1:0]  r_gnt_idx, w_gnt_idx_nxt;
  logic [IDX_W-1:0]  r_widx, w_widx_nxt;
  logic [IDX_W-1:0]  r_ptr, w_ptr_nxt;
  logic [N_REQ-1:0]  r_revoked, w_revoked_nxt;
  logic [GAP_W-1:0]  r_gap_cnt, w_gap_cnt_nxt;
  logic [HOLD_W-1:0] r_hold_cnt, w_hold_cnt_nxt;
  logic              r_gnt_valid, r_busy, r_timeout, w_timeout_nxt;

  logic [N_REQ-1:0]  w_pick_onehot;
  logic [IDX_W-1:0]  w_pick_idx;
  logic              w_pick_any;
  logic              w_req_w;

  rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
    .i_req    (bus.req & ~r_revoked),
    .i_ptr    (r_ptr),
    .o_onehot (w_pick_onehot),
    .o_idx    (w_pick_idx),
    .o_any    (w_pick_any)
  );

  assign w_req_w = bus.req[r_widx];

  // Next-state and next-output logic; release is tested before the watchdog.
  always_comb begin
    w_state_nxt    = r_state;
    w_gnt_nxt      = r_gnt;
    w_gnt_idx_nxt  = r_gnt_idx;
    w_widx_nxt     = r_widx;
    w_ptr_nxt      = r_ptr;
    w_gap_cnt_nxt  = r_gap_cnt;
    w_hold_cnt_nxt = r_hold_cnt;
    w_timeout_nxt  = 1'b0;
    w_revoked_nxt  = r_revoked & bus.req;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_any) begin
          w_gnt_nxt      = w_pick_onehot;
          w_gnt_idx_nxt  = w_pick_idx;
          w_widx_nxt     = w_pick_idx;
          w_ptr_nxt      = (w_pick_idx == LAST_IDX) ? {IDX_W{1'b0}} : w_pick_idx + 1'b1;
          w_hold_cnt_nxt = 16'd1;
          w_state_nxt    = ST_GRANT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (!w_req_w) begin
          w_gnt_nxt     = {N_REQ{1'b0}};
          w_gnt_idx_nxt = {IDX_W{1'b0}};
          w_gap_cnt_nxt = 4'd1;
          w_state_nxt   = ST_REL;
        end else if ((MAX_HOLD != 16'd0) && (r_hold_cnt == MAX_HOLD)) begin
          w_gnt_nxt     = {N_REQ{1'b0}};
          w_gnt_idx_nxt = {IDX_W{1'b0}};
          w_timeout_nxt = 1'b1;
          w_revoked_nxt = w_revoked_nxt | (ONE_N << r_widx);
          w_state_nxt   = ST_WAITREL;
        end else begin
          w_hold_cnt_nxt = r_hold_cnt + 16'd1;
        end
      end
      ST_WAITREL: begin
        if (!w_req_w) begin
          w_gap_cnt_nxt = 4'd1;
          w_state_nxt   = ST_REL;
        end else begin
          w_state_nxt = ST_WAITREL;
        end
      end
      ST_GAP: begin
        if (r_gap_cnt >= GAP_LIM) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt + 4'd1;
        end
      end
      default: begin
        w_state_nxt   = ST_IDLE;
        w_gnt_nxt     = {N_REQ{1'b0}};
        w_gnt_idx_nxt = {IDX_W{1'b0}};
      end
    endcase
  end

  // State and registered outputs; synchronous reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst_sync) begin
      r_state     <= ST_IDLE;
      r_gnt       <= {N_REQ{1'b0}};
      r_gnt_idx   <= {IDX_W{1'b0}};
      r_widx      <= {IDX_W{1'b0}};
      r_ptr       <= {IDX_W{1'b0}};
      r_revoked   <= {N_REQ{1'b0}};
      r_gap_cnt   <= 4'd0;
      r_hold_cnt  <= 16'd0;
      r_gnt_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_gnt       <= w_gnt_nxt;
      r_gnt_idx   <= w_gnt_idx_nxt;
      r_widx      <= w_widx_nxt;
      r_ptr       <= w_ptr_nxt;
      r_revoked   <= w_revoked_nxt;
      r_gap_cnt   <= w_gap_cnt_nxt;
      r_hold_cnt  <= w_hold_cnt_nxt;
      r_gnt_valid <= |w_gnt_nxt;
      r_busy      <= (w_state_nxt != ST_IDLE);
      r_timeout   <= w_timeout_nxt;
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.gnt_valid = r_gnt_valid;
  assign bus.gnt_idx   = r_gnt_idx;
  assign bus.busy      = r_busy;
  assign bus.timeout   = r_timeout;
  assign bus.revoked   = r_revoked;

endmodule

// File: tb/tb_hs4_rr_arbiter.sv
// Cycle-by-cycle bench for hs4_rr_arbiter (N_REQ=4, GAP_CYC=1, MAX_HOLD=8):
// a vector table plus a hand-written watchdog sequence, checked via a queue.
module tb_hs4_rr_arbiter;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       busy;
    logic       tmo;
    logic [3:0] rev;
  } vec_t;

  logic clk;
  logic rst_sync;
  int   checks;
  int   errors;
  vec_t vecs[$];
  vec_t sb_q[$];

  hs4_rr_arbiter_if #(.N_REQ(4)) u_if ();

  hs4_rr_arbiter #(.N_REQ(4), .GAP_CYC(1), .MAX_HOLD(16'd8)) dut (
    .clk      (clk),
    .rst_sync (rst_sync),
    .bus      (u_if)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic rst, input logic [3:0] req, input logic [3:0] gnt,
                              input logic [1:0] idx, input logic busy, input logic tmo,
                              input logic [3:0] rev);
    vec_t v;
    v.rst = rst; v.req = req; v.gnt = gnt; v.idx = idx;
    v.busy = busy; v.tmo = tmo; v.rev = rev;
    return v;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag);
    vec_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb_q.pop_front();
      cmp({tag, " gnt"},       32'(u_if.gnt),       32'(e.gnt));
      cmp({tag, " gnt_idx"},   32'(u_if.gnt_idx),   32'(e.idx));
      cmp({tag, " gnt_valid"}, 32'(u_if.gnt_valid), 32'(e.gnt != 4'd0));
      cmp({tag, " busy"},      32'(u_if.busy),      32'(e.busy));
      cmp({tag, " timeout"},   32'(u_if.timeout),   32'(e.tmo));
      cmp({tag, " revoked"},   32'(u_if.revoked),   32'(e.rev));
      cmp({tag, " onehot0"},   32'($onehot0(u_if.gnt)), 32'd1);
    end
  endtask

  task automatic step(input vec_t v, input string tag);
    @(negedge clk);
    rst_sync   = v.rst;
    u_if.req   = v.req;
    sb_q.push_back(v);
    @(posedge clk);
    #1;
    check_out(tag);
  endtask

  initial begin
    clk      = 1'b0;
    rst_sync = 1'b1;
    u_if.req = 4'b0000;

    // reset, then reset mid-grant of requester 2
    vecs.push_back(mk(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 4'b0000));
    vecs.push_back(mk(1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0, 4'b0000));
    vecs.push_back(mk(1'b1, 4'b0100, 4'b0000, 2'd0, 1'b0, 1'b0, 4'b0000));
    vecs.push_back(mk(1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0, 4'b0000));
    vecs.push_back(mk(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0, 4'b0000));
    vecs.push_back(mk(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 4'b0000));
    // single handshake (ptr=3 wraps to 0), then req[1] raised during the gap
    vecs.push_back(mk(1'b0, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0, 4'b0000));
    vecs.push_back(mk(1'b0, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0, 4'b0000));
    vecs.push_back(mk(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0, 4'b0000));
    vecs.push_back(mk(1'b0, 4'b0010, 4'b0000, 2'd0, 1'b0, 1'b0, 4'b0000));
    vecs.push_back(mk(1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0, 4'b0000));
    vecs.push_back(mk(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0, 4'b0000));
    vecs.push_back(mk(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 4'b0000));
    // round robin with all four requesting, ptr back to 0
    vecs.push_back(mk(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 4'b0000));
    for (int i = 0; i < 4; i++) begin
      logic [3:0] bit_w;
      bit_w = 4'b0001 << i;
      vecs.push_back(mk(1'b0, 4'b1111, bit_w, 2'(i), 1'b1, 1'b0, 4'b0000));
      vecs.push_back(mk(1'b0, 4'b1111 & ~bit_w, 4'b0000, 2'd0, 1'b1, 1'b0, 4'b0000));
      vecs.push_back(mk(1'b0, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0, 4'b0000));
    end
    vecs.push_back(mk(1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0, 4'b0000));
    vecs.push_back(mk(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0, 4'b0000));
    vecs.push_back(mk(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 4'b0000));
    // release on the very cycle the watchdog would expire: release wins
    for (int i = 0; i < 8; i++) begin
      vecs.push_back(mk(1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0, 4'b0000));
    end
    vecs.push_back(mk(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0, 4'b0000));
    vecs.push_back(mk(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 4'b0000));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i], $sformatf("row%0d", i));
    end

    // watchdog: requester 2 holds past 8 grant cycles
    for (int i = 0; i < 8; i++) begin
      step(mk(1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0, 4'b0000), $sformatf("wd_hold%0d", i));
    end
    step(mk(1'b0, 4'b0100, 4'b0000, 2'd0, 1'b1, 1'b1, 4'b0100), "wd_revoke");
    for (int i = 0; i < 3; i++) begin
      step(mk(1'b0, 4'b1100, 4'b0000, 2'd0, 1'b1, 1'b0, 4'b0100), $sformatf("wd_wait%0d", i));
    end
    step(mk(1'b0, 4'b1000, 4'b0000, 2'd0, 1'b1, 1'b0, 4'b0000), "wd_release");
    step(mk(1'b0, 4'b1000, 4'b0000, 2'd0, 1'b0, 1'b0, 4'b0000), "wd_idle");
    step(mk(1'b0, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0, 4'b0000), "wd_grant3");
    step(mk(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0, 4'b0000), "wd_gap");
    step(mk(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 4'b0000), "wd_end");

    cmp("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
